cpu_bus_responder: RTL and testbench

- Slave-side endpoint of the external CPU parallel bus: chip select, write enable, 17-bit address and 16-bit data.
- Decodes each bus access into exactly one write strobe, or one read request, on the internal BRAM/config port.
- Drives read data back onto the bus.
- Sits between the FPGA pins and the per-select BRAMs (select 0 = config, 1–3 = mod/normal/seq memories).

---
 rtl/cpu_bus_responder_if.sv | 19 +
 rtl/cpu_bus_responder.sv | 188 ++++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_responder_if.sv
// CPU parallel bus as seen at the FPGA pins: strobes, address and data in, read data and pad enable out.
interface cpu_bus_responder_if;
  logic        CS_N;
  logic        WE_N;
  logic [16:0] ADDR;
  logic [15:0] DATA_IN;
  logic [15:0] DATA_OUT;
  logic        DATA_OE;

  modport master (
    output CS_N, WE_N, ADDR, DATA_IN,
    input  DATA_OUT, DATA_OE
  );

  modport slave (
    input  CS_N, WE_N, ADDR, DATA_IN,
    output DATA_OUT, DATA_OE
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// CPU bus slave: each access becomes one BRAM write strobe or one read, read data driven back to the pads.
// Write strobe 3 cycles after pins go low; DATA_OE rises 1+BRAM_LATENCY+1 cycles after registered CS low.
module cpu_bus_responder #(
  parameter int BRAM_LATENCY = 2,
  parameter int WR_SETTLE    = 2
) (
  input  logic                CLK,
  input  logic                RST,
  cpu_bus_responder_if.slave  bus,
  output logic [3:0]          BRAM_WE,
  output logic [3:0]          BRAM_RE,
  output logic [13:0]         BRAM_ADDR,
  output logic [15:0]         BRAM_DIN,
  input  logic [15:0]         BRAM_DOUT_0,
  input  logic [15:0]         BRAM_DOUT_1,
  input  logic [15:0]         BRAM_DOUT_2,
  input  logic [15:0]         BRAM_DOUT_3,
  output logic [15:0]         WR_COUNT
);

  localparam int SW = ($clog2(WR_SETTLE + 1) < 1) ? 1 : $clog2(WR_SETTLE + 1);
  localparam int RW = ($clog2(BRAM_LATENCY + 1) < 1) ? 1 : $clog2(BRAM_LATENCY + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(WR_SETTLE - 1);
  localparam logic [RW-1:0] RD_LAST     = RW'(BRAM_LATENCY);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETTLE,
    ST_WR_HOLD,
    ST_RD_WAIT,
    ST_RD_DRIVE
  } state_t;

  state_t        state;
  state_t        state_d;

  logic          cs_q;
  logic          we_q;
  logic [1:0]    sel_q;
  logic [13:0]   waddr_q;
  logic [15:0]   din_q;
  logic          unused_addr_lsb;

  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] settle_cnt_d;
  logic [RW-1:0] rd_cnt;
  logic [RW-1:0] rd_cnt_d;

  logic          wr_commit;
  logic          rd_start;
  logic          rd_capture;
  logic [1:0]    rd_sel;
  logic [15:0]   rd_mux;
  logic [15:0]   data_out_q;

  // Byte lane bit of the CPU address carries no meaning on a 16-bit bus.
  assign unused_addr_lsb = bus.ADDR[0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cs_q    <= 1'b1;
      we_q    <= 1'b1;
      sel_q   <= '0;
      waddr_q <= '0;
      din_q   <= '0;
    end else begin
      cs_q    <= bus.CS_N;
      we_q    <= bus.WE_N;
      sel_q   <= bus.ADDR[16:15];
      waddr_q <= bus.ADDR[14:1];
      din_q   <= bus.DATA_IN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      rd_cnt     <= '0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_cnt_d;
      rd_cnt     <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    settle_cnt_d = settle_cnt;
    rd_cnt_d     = rd_cnt;
    wr_commit    = 1'b0;
    rd_start     = 1'b0;
    rd_capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!cs_q) begin
          if (!we_q) begin
            state_d      = ST_WR_SETTLE;
            settle_cnt_d = SW'(1);
          end else begin
            state_d  = ST_RD_WAIT;
            rd_start = 1'b1;
            rd_cnt_d = '0;
          end
        end
      end
      ST_WR_SETTLE: begin
        if (cs_q || we_q) begin
          state_d = ST_IDLE;
        end else if (settle_cnt >= SETTLE_LAST) begin
          wr_commit = 1'b1;
          state_d   = ST_WR_HOLD;
        end else begin
          settle_cnt_d = settle_cnt + SW'(1);
        end
      end
      ST_WR_HOLD: begin
        // One strobe per low pulse: only a release of CS or WE re-arms the decoder.
        if (cs_q || we_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (cs_q) begin
          state_d = ST_IDLE;
        end else if (rd_cnt == RD_LAST) begin
          rd_capture = 1'b1;
          state_d    = ST_RD_DRIVE;
        end else begin
          rd_cnt_d = rd_cnt + RW'(1);
        end
      end
      ST_RD_DRIVE: begin
        if (cs_q) begin
          state_d = ST_IDLE;
        end else if (!we_q) begin
          state_d      = ST_WR_SETTLE;
          settle_cnt_d = SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = BRAM_DOUT_0;
    case (rd_sel)
      2'd0:    rd_mux = BRAM_DOUT_0;
      2'd1:    rd_mux = BRAM_DOUT_1;
      2'd2:    rd_mux = BRAM_DOUT_2;
      default: rd_mux = BRAM_DOUT_3;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BRAM_WE    <= '0;
      BRAM_RE    <= '0;
      BRAM_ADDR  <= '0;
      BRAM_DIN   <= '0;
      WR_COUNT   <= '0;
      rd_sel     <= '0;
      data_out_q <= '0;
    end else begin
      BRAM_WE <= '0;
      BRAM_RE <= '0;
      if (rd_start) begin
        BRAM_RE   <= 4'b0001 << sel_q;
        BRAM_ADDR <= waddr_q;
        rd_sel    <= sel_q;
      end
      if (wr_commit) begin
        BRAM_WE   <= 4'b0001 << sel_q;
        BRAM_ADDR <= waddr_q;
        BRAM_DIN  <= din_q;
        WR_COUNT  <= WR_COUNT + 16'd1;
      end
      if (rd_capture) begin
        data_out_q <= rd_mux;
      end
    end
  end

  // Pad enable follows the registered strobes combinationally so it drops in the release cycle.
  assign bus.DATA_OE  = (state == ST_RD_DRIVE) && !cs_q && we_q;
  assign bus.DATA_OUT = data_out_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Bench for cpu_bus_responder: table of bus accesses plus hand sequences for reset and read-then-write.
module tb_cpu_bus_responder;
  localparam int BRAM_LATENCY = 2;
  localparam int WR_SETTLE    = 2;
  // posedges from driving CS low to seeing DATA_OE: one input register, then 1+latency+1
  localparam int RD_OE_EDGES  = 1 + (1 + BRAM_LATENCY + 1);

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  BRAM_WE;
  logic [3:0]  BRAM_RE;
  logic [13:0] BRAM_ADDR;
  logic [15:0] BRAM_DIN;
  logic [15:0] WR_COUNT;
  logic [15:0] bram_dout [4];

  cpu_bus_responder_if bus();

  cpu_bus_responder #(.BRAM_LATENCY(BRAM_LATENCY), .WR_SETTLE(WR_SETTLE)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .BRAM_WE    (BRAM_WE),
    .BRAM_RE    (BRAM_RE),
    .BRAM_ADDR  (BRAM_ADDR),
    .BRAM_DIN   (BRAM_DIN),
    .BRAM_DOUT_0(bram_dout[0]),
    .BRAM_DOUT_1(bram_dout[1]),
    .BRAM_DOUT_2(bram_dout[2]),
    .BRAM_DOUT_3(bram_dout[3]),
    .WR_COUNT   (WR_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_wr;
    logic [3:0]  strobe;
    logic [13:0] addr;
    logic [15:0] din;
  } exp_t;

  typedef struct {
    bit          rst_first;
    bit          is_rd;
    logic [1:0]  sel;
    logic [13:0] wa;
    logic [15:0] data;
    int          hold;
    int          idle_after;
    logic [15:0] exp_cnt;
    logic [15:0] exp_dout;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   we_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    logic [3:0] one;
    one = 4'b0001;
    return one << sel;
  endfunction

  function automatic logic [16:0] cpu_addr(input logic [1:0] sel, input logic [13:0] wa);
    return {sel, wa, wa[0]};
  endfunction

  // Strobe scoreboard: every WE/RE pulse must match the oldest expected access.
  always @(posedge CLK) begin
    #1;
    if (BRAM_WE != 4'b0) we_pulses++;
    if (BRAM_WE != 4'b0 || BRAM_RE != 4'b0) begin
      check("strobe_excl", 32'(BRAM_WE != 4'b0 && BRAM_RE != 4'b0), 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: WE=%b RE=%b with no access pending at %0t", BRAM_WE, BRAM_RE, $time);
      end else begin
        mon_e = sb.pop_front();
        check("sb_we", 32'(BRAM_WE), mon_e.is_wr ? 32'(mon_e.strobe) : 32'd0);
        check("sb_re", 32'(BRAM_RE), mon_e.is_wr ? 32'd0 : 32'(mon_e.strobe));
        check("sb_addr", 32'(BRAM_ADDR), 32'(mon_e.addr));
        if (mon_e.is_wr) check("sb_din", 32'(BRAM_DIN), 32'(mon_e.din));
      end
    end
  end

  task automatic bus_idle();
    bus.CS_N = 1'b1;
    bus.WE_N = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    bus_idle();
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] sel, input logic [13:0] wa, input logic [15:0] d, input int hold);
    @(negedge CLK);
    bus.CS_N    = 1'b0;
    bus.WE_N    = 1'b0;
    bus.ADDR    = cpu_addr(sel, wa);
    bus.DATA_IN = d;
    if (hold >= WR_SETTLE) sb.push_back('{1'b1, onehot(sel), wa, d});
    for (int i = 1; i < hold; i++) begin
      @(negedge CLK);
      if (i == 4) bus.DATA_IN = ~d;
    end
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic wait_oe(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge CLK);
      #1;
      lat++;
      if (bus.DATA_OE) break;
    end
  endtask

  task automatic start_read(input logic [1:0] sel, input logic [13:0] wa);
    @(negedge CLK);
    bus.CS_N = 1'b0;
    bus.WE_N = 1'b1;
    bus.ADDR = cpu_addr(sel, wa);
    sb.push_back('{1'b0, onehot(sel), wa, 16'h0});
  endtask

  task automatic do_read(input logic [1:0] sel, input logic [13:0] wa, input logic [15:0] exp_dout);
    int lat;
    start_read(sel, wa);
    wait_oe(lat);
    check("rd_oe_latency", 32'(lat), 32'(RD_OE_EDGES));
    check("rd_data", 32'(bus.DATA_OUT), 32'(exp_dout));
    idle(3);
    check("rd_oe_hold", 32'(bus.DATA_OE), 32'd1);
    check("rd_data_stable", 32'(bus.DATA_OUT), 32'(exp_dout));
    bus_idle();
    @(posedge CLK);
    #1;
    check("rd_oe_drop", 32'(bus.DATA_OE), 32'd0);
  endtask

  vec_t vt[11];

  initial begin
    int lat;
    int p0;
    vt[0]  = '{1'b0, 1'b0, 2'd0, 14'h0008, 16'd8500,  10, 3,  16'd1, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 2'd3, 14'h01F8, 16'hCCDD,  4,  20, 16'd1, 16'h0000};
    vt[2]  = '{1'b0, 1'b0, 2'd3, 14'h0000, 16'h1122,  4,  3,  16'd2, 16'h0000};
    vt[3]  = '{1'b0, 1'b0, 2'd1, 14'h0005, 16'hDEAD,  1,  3,  16'd2, 16'h0000};
    vt[4]  = '{1'b0, 1'b1, 2'd0, 14'h0000, 16'h0000,  0,  2,  16'd2, 16'h8010};
    vt[5]  = '{1'b0, 1'b1, 2'd2, 14'h3FFF, 16'h0000,  0,  2,  16'd2, 16'hC3C3};
    vt[6]  = '{1'b0, 1'b0, 2'd1, 14'h3FFF, 16'hFFFF,  2,  0,  16'd3, 16'h0000};
    vt[7]  = '{1'b0, 1'b0, 2'd2, 14'h2AAA, 16'h0000,  3,  0,  16'd4, 16'h0000};
    vt[8]  = '{1'b0, 1'b1, 2'd1, 14'h1234, 16'h0000,  0,  2,  16'd4, 16'h5A5A};
    vt[9]  = '{1'b0, 1'b1, 2'd3, 14'h0001, 16'h0000,  0,  2,  16'd4, 16'h0F0F};
    vt[10] = '{1'b0, 1'b0, 2'd0, 14'h0077, 16'h1357,  1,  3,  16'd4, 16'h0000};

    bram_dout[0] = 16'h8010;
    bram_dout[1] = 16'h5A5A;
    bram_dout[2] = 16'hC3C3;
    bram_dout[3] = 16'h0F0F;
    bus.ADDR     = '0;
    bus.DATA_IN  = '0;
    bus_idle();
    RST = 1'b1;
    idle(2);
    check("rst_we", 32'(BRAM_WE), 32'd0);
    check("rst_re", 32'(BRAM_RE), 32'd0);
    check("rst_addr", 32'(BRAM_ADDR), 32'd0);
    check("rst_din", 32'(BRAM_DIN), 32'd0);
    check("rst_count", 32'(WR_COUNT), 32'd0);
    check("rst_dout", 32'(bus.DATA_OUT), 32'd0);
    check("rst_oe", 32'(bus.DATA_OE), 32'd0);
    RST = 1'b0;
    idle(2);

    for (int i = 0; i < 11; i++) begin
      if (vt[i].rst_first) pulse_reset();
      if (vt[i].is_rd) begin
        do_read(vt[i].sel, vt[i].wa, vt[i].exp_dout);
      end else begin
        do_write(vt[i].sel, vt[i].wa, vt[i].data, vt[i].hold);
        idle(3);
        if (vt[i].hold >= WR_SETTLE) begin
          check("wr_addr", 32'(BRAM_ADDR), 32'(vt[i].wa));
          check("wr_din", 32'(BRAM_DIN), 32'(vt[i].data));
        end
      end
      idle(vt[i].idle_after);
      check("vec_count", 32'(WR_COUNT), 32'(vt[i].exp_cnt));
    end

    // reset while holding a committed write
    @(negedge CLK);
    bus.CS_N = 1'b0; bus.WE_N = 1'b0; bus.ADDR = cpu_addr(2'd2, 14'h0ABC); bus.DATA_IN = 16'h7777;
    sb.push_back('{1'b1, onehot(2'd2), 14'h0ABC, 16'h7777});
    idle(5);
    RST = 1'b1;
    #1;
    check("hold_rst_oe", 32'(bus.DATA_OE), 32'd0);
    check("hold_rst_we", 32'(BRAM_WE), 32'd0);
    check("hold_rst_re", 32'(BRAM_RE), 32'd0);
    check("hold_rst_count", 32'(WR_COUNT), 32'd0);
    @(negedge CLK);
    bus_idle();
    idle(1);
    RST = 1'b0;
    do_write(2'd1, 14'h0042, 16'h4242, 3);
    idle(3);
    check("post_rst_count", 32'(WR_COUNT), 32'd1);
    check("post_rst_addr", 32'(BRAM_ADDR), 32'h42);

    // reset while the glitch filter is still counting: no strobe may follow
    p0 = we_pulses;
    @(negedge CLK);
    bus.CS_N = 1'b0; bus.WE_N = 1'b0; bus.ADDR = cpu_addr(2'd0, 14'h0011); bus.DATA_IN = 16'h9999;
    idle(2);
    RST = 1'b1;
    bus_idle();
    idle(2);
    RST = 1'b0;
    idle(4);
    check("settle_rst_pulses", 32'(we_pulses - p0), 32'd0);
    check("settle_rst_count", 32'(WR_COUNT), 32'd0);

    // reset while driving read data
    start_read(2'd1, 14'h0007);
    wait_oe(lat);
    check("drive_rst_reach", 32'(lat), 32'(RD_OE_EDGES));
    RST = 1'b1;
    #1;
    check("drive_rst_oe", 32'(bus.DATA_OE), 32'd0);
    check("drive_rst_dout", 32'(bus.DATA_OUT), 32'd0);
    @(negedge CLK);
    bus_idle();
    idle(1);
    RST = 1'b0;
    idle(2);

    // read then write inside a single chip select
    start_read(2'd3, 14'h0100);
    wait_oe(lat);
    check("rw_rd_latency", 32'(lat), 32'(RD_OE_EDGES));
    check("rw_rd_data", 32'(bus.DATA_OUT), 32'h0F0F);
    @(negedge CLK);
    bus.WE_N = 1'b0;
    bus.DATA_IN = 16'hBEEF;
    sb.push_back('{1'b1, onehot(2'd3), 14'h0100, 16'hBEEF});
    @(posedge CLK);
    #1;
    check("rw_oe_drop", 32'(bus.DATA_OE), 32'd0);
    idle(3);
    bus_idle();
    idle(3);
    check("rw_count", 32'(WR_COUNT), 32'd1);
    check("rw_din", 32'(BRAM_DIN), 32'hBEEF);

    // counter wrap over a full 16-bit range of back-to-back writes
    pulse_reset();
    p0 = we_pulses;
    for (int i = 0; i < 65536; i++) begin
      @(negedge CLK);
      bus.CS_N = 1'b0; bus.WE_N = 1'b0;
      bus.ADDR = cpu_addr(2'(i), 14'(i >> 2));
      bus.DATA_IN = 16'(i ^ 16'hA5A5);
      sb.push_back('{1'b1, onehot(2'(i)), 14'(i >> 2), 16'(i ^ 16'hA5A5)});
      @(negedge CLK);
      @(negedge CLK);
      bus_idle();
      if (i == 65534) begin
        idle(3);
        check("wrap_pre", 32'(WR_COUNT), 32'hFFFF);
      end
    end
    idle(3);
    check("wrap_zero", 32'(WR_COUNT), 32'h0000);
    check("wrap_pulses", 32'(we_pulses - p0), 32'd65536);

    idle(5);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not reach the summary within the time limit");
    $fatal(1, "timeout");
  end

endmodule
